prefetch_queue: RTL and testbench
=================================

Name: prefetch_queue

Overview:
Parameterised instruction-byte prefetch queue between the memory fetch path and the prime decoder of the 6502 core. Memory writes one byte per cycle. The decoder sees a window of up to MAX_PULL head bytes and retires 1..MAX_PULL bytes in a single cycle, matching the instruction length from address-mode decode. A taken branch or an interrupt discards the queue contents in one cycle. The block also tells the fetch unit when it may issue more reads.

Parameters:
DATA_W, 8, width of one queue entry in bits
DEPTH, 16, number of entries; must be a power of two and at least MAX_PULL+1
MAX_PULL, 3, maximum bytes retired per cycle (longest 6502 instruction)
REFILL_LVL, 4, refill_req is asserted while count is at or below this value
CNT_W, $clog2(DEPTH+1), width of count (derived, not overridable)

Ports:
clk  in  1  core clock; all state updates on the rising edge
queue_reset  in  1  synchronous, active-high reset
flush  in  1  discard all entries (branch taken or interrupt)
push  in  1  write push_data this cycle
push_data  in  DATA_W  byte from memory
full  out  1  count == DEPTH
pull  in  1  retire pull_len bytes this cycle
pull_len  in  $clog2(MAX_PULL+1)  bytes to retire, 1..MAX_PULL
pull_ack  out  1  combinational; pull accepted this cycle
win_data  out  MAX_PULL*DATA_W  head bytes; lane 0 (LSBs) = oldest
win_valid  out  MAX_PULL  lane i valid when count > i
count  out  CNT_W  number of occupied entries
refill_req  out  1  count <= REFILL_LVL and no flush this cycle
overflow  out  1  sticky; a push was attempted while full

Behaviour:
- One clock domain, synchronous active-high reset on queue_reset.
- Reset values: ptr_s=0, ptr_e=0, count=0, overflow=0. Outputs after reset: full=0, win_valid=0, refill_req=1 when REFILL_LVL>=0.
- While in reset, win_data is don't-care. The memory array is not cleared.
- Storage is DEPTH x DATA_W registers. ptr_s (head) and ptr_e (tail) are log2(DEPTH) bits wide and wrap naturally modulo DEPTH.
- win_data lane i = mem[(ptr_s+i) mod DEPTH]. This is combinational from the registered state, so the window shows its new contents in the cycle after a pull.
- pull_ack = pull && pull_len != 0 && pull_len <= count && !flush. The check uses count before this cycle's push, so there is no push-to-pull bypass.
- A pull that is not acknowledged has no effect. The decoder holds pull and pull_len until pull_ack.
- Push is accepted when push && !full && !flush. full is evaluated before this cycle's pull, so there is no pull-to-push bypass.
- A push while full is dropped and sets overflow. overflow clears only on queue_reset.
- On an accepted push: mem[ptr_e] <= push_data and ptr_e increments.
- On an accepted pull: ptr_s advances by pull_len.
- Next count = count + accepted push - accepted pull_len. Simultaneous push and pull are legal. When count==DEPTH, a pull and a refused push give DEPTH-pull_len.
- Flush (with queue_reset low): ptr_s <= ptr_e and count <= 0 on the next edge. The same-cycle push and pull are discarded, and overflow is kept.
- Priority: queue_reset > flush > push/pull.
- refill_req is combinational; the fetch unit issues reads only while it is high. The REFILL_LVL margin covers memory latency.
- count never exceeds DEPTH and never underflows. Verification asserts both.

Decomposition:
- Shared package (core_pkg): BYTE_W=8, MAX_INST_LEN=3, and a pull-length type for 1..3.
- Optional sub-module queue_window_mux: generates the MAX_PULL-lane rotated read from the array and ptr_s. Everything else stays in prefetch_queue.

Test Plan:
- Reset then push 0x10..0x13 over 4 cycles -> count=4; win_data lanes = 0x10,0x11,0x12; win_valid=3'b111.
- From count=4, pull len 3 -> pull_ack=1; next cycle count=1, lane0=0x13, win_valid=3'b001. Then pull len 2 -> pull_ack=0 and count stays 1.
- Fill 16 bytes 0x00..0x0F -> full=1. Push 0xAA -> dropped and overflow=1. Next cycle: pull len 1 plus push 0xBB -> pull accepted, push dropped, count=15.
- Wrap-around: 20 pushes interleaved with len-2 pulls across the 15->0 pointer boundary -> window bytes stay in strict push order and count matches a scoreboard.
- Flush at count=7 with same-cycle push 0x55 and pull len 1 -> next cycle count=0, win_valid=0, refill_req=1, 0x55 never appears. A following push of 0x66 appears in lane0.
- queue_reset asserted together with flush, push and pull at count=9 -> next cycle count=0, overflow=0, full=0.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared 6502 core constants and types
// Contents:
//   BYTE_W        width of one instruction byte
//   MAX_INST_LEN  longest 6502 instruction in bytes
//   pull_len_t    decoder retire length, legal values 1..MAX_INST_LEN
package core_pkg;

  localparam int BYTE_W       = 8;
  localparam int MAX_INST_LEN = 3;

  typedef logic [1:0] pull_len_t;

endpackage

// File: rtl/queue_window_mux.sv
// rtl/queue_window_mux.sv - rotated head-window read from the prefetch array
// Ports:
//   mem_flat  in   DEPTH*DATA_W    flattened storage, entry k at bits [k*DATA_W +: DATA_W]
//   ptr_s     in   log2(DEPTH)     head pointer
//   win_data  out  MAX_PULL*DATA_W lane i = entry (ptr_s+i) mod DEPTH
module queue_window_mux #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int MAX_PULL = 3,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic [DEPTH*DATA_W-1:0]    mem_flat,
  input  logic [PTR_W-1:0]           ptr_s,
  output logic [MAX_PULL*DATA_W-1:0] win_data
);

  for (genvar g = 0; g < MAX_PULL; g++) begin : g_lane
    logic [PTR_W-1:0] idx;
    // PTR_W-bit add wraps modulo DEPTH, giving the rotation for free.
    assign idx = ptr_s + PTR_W'(g);
    assign win_data[g*DATA_W +: DATA_W] = mem_flat[idx*DATA_W +: DATA_W];
  end

endmodule

// File: rtl/prefetch_queue.sv
// rtl/prefetch_queue.sv - instruction-byte prefetch queue feeding the decoder
// Ports:
//   clk          in   1                core clock
//   queue_reset  in   1                synchronous active-high reset
//   flush        in   1                discard all entries
//   push         in   1                write push_data this cycle
//   push_data    in   DATA_W           byte from memory
//   full         out  1                count == DEPTH
//   pull         in   1                retire pull_len bytes
//   pull_len     in   PL_W             bytes to retire, 1..MAX_PULL
//   pull_ack     out  1                pull accepted this cycle (combinational)
//   win_data     out  MAX_PULL*DATA_W  head bytes, lane 0 oldest
//   win_valid    out  MAX_PULL         lane i valid when count > i
//   count        out  CNT_W            occupied entries
//   refill_req   out  1                fetch may issue reads
//   overflow     out  1                sticky push-while-full flag
module prefetch_queue
  import core_pkg::*;
#(
  parameter int DATA_W     = BYTE_W,
  parameter int DEPTH      = 16,
  parameter int MAX_PULL   = MAX_INST_LEN,
  parameter int REFILL_LVL = 4,
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int PL_W      = $clog2(MAX_PULL + 1)
) (
  input  logic                       clk,
  input  logic                       queue_reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  output logic                       full,
  input  logic                       pull,
  input  logic [PL_W-1:0]            pull_len,
  output logic                       pull_ack,
  output logic [MAX_PULL*DATA_W-1:0] win_data,
  output logic [MAX_PULL-1:0]        win_valid,
  output logic [CNT_W-1:0]           count,
  output logic                       refill_req,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  ptr_s_q, ptr_s_d;
  logic [PTR_W-1:0]  ptr_e_q, ptr_e_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH*DATA_W-1:0] mem_flat;

  logic              full_c;
  logic              push_ok;
  logic              pull_ok;
  logic [CNT_W-1:0]  pull_len_c;

  always_comb begin
    full_c     = (count_q == CNT_W'(DEPTH));
    pull_len_c = CNT_W'(pull_len);
    // Both acceptance checks use the registered count: no push-to-pull or
    // pull-to-push bypass, so a full queue refuses a push even while pulling.
    pull_ok    = pull && (pull_len != '0) && (pull_len_c <= count_q) && !flush;
    push_ok    = push && !full_c && !flush;

    ptr_s_d    = ptr_s_q;
    ptr_e_d    = ptr_e_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push && full_c && !flush);

    if (flush) begin
      ptr_s_d = ptr_e_q;
      count_d = '0;
    end else begin
      if (push_ok) ptr_e_d = ptr_e_q + PTR_W'(1);
      if (pull_ok) ptr_s_d = ptr_s_q + PTR_W'(pull_len);
      count_d = count_q + CNT_W'(push_ok) - (pull_ok ? pull_len_c : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (queue_reset) begin
      ptr_s_q    <= '0;
      ptr_e_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      ptr_s_q    <= ptr_s_d;
      ptr_e_q    <= ptr_e_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is never cleared; stale bytes are masked by win_valid.
  always_ff @(posedge clk) begin
    if (push_ok && !queue_reset) mem_q[ptr_e_q] <= push_data;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign mem_flat[g*DATA_W +: DATA_W] = mem_q[g];
  end

  queue_window_mux #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .MAX_PULL(MAX_PULL)
  ) u_window (
    .mem_flat(mem_flat),
    .ptr_s   (ptr_s_q),
    .win_data(win_data)
  );

  always_comb begin
    win_valid = '0;
    for (int i = 0; i < MAX_PULL; i++) win_valid[i] = (count_q > CNT_W'(i));
  end

  assign full       = full_c;
  assign pull_ack   = pull_ok;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign refill_req = (count_q <= CNT_W'(REFILL_LVL)) && !flush;

endmodule

// File: tb/tb_prefetch_queue.sv
// tb/tb_prefetch_queue.sv - scoreboard bench for prefetch_queue
module tb_prefetch_queue;

  logic        clk = 1'b0;
  logic        queue_reset, flush, push, pull;
  logic [7:0]  push_data;
  logic [1:0]  pull_len;
  logic        full, pull_ack, refill_req, overflow;
  logic [23:0] win_data;
  logic [2:0]  win_valid;
  logic [4:0]  count;

  always #5 clk = ~clk;

  prefetch_queue dut (
    .clk        (clk),
    .queue_reset(queue_reset),
    .flush      (flush),
    .push       (push),
    .push_data  (push_data),
    .full       (full),
    .pull       (pull),
    .pull_len   (pull_len),
    .pull_ack   (pull_ack),
    .win_data   (win_data),
    .win_valid  (win_valid),
    .count      (count),
    .refill_req (refill_req),
    .overflow   (overflow)
  );

  typedef enum int {K_CNT, K_LANE, K_WV, K_FULL, K_OVF, K_REFILL, K_ACK} kind_t;
  typedef struct {
    int    cyc;
    kind_t kind;
    int    lane;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(kind_t k, int lane, int val, string name);
    exp_t e;
    e.cyc = cyc; e.kind = k; e.lane = lane; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  function automatic int actual(kind_t k, int lane);
    case (k)
      K_CNT:    return int'(count);
      K_LANE:   return int'(win_data[lane*8 +: 8]);
      K_WV:     return int'(win_valid);
      K_FULL:   return int'(full);
      K_OVF:    return int'(overflow);
      K_REFILL: return int'(refill_req);
      default:  return int'(pull_ack);
    endcase
  endfunction

  // Monitor: pops every expectation due in the current cycle, mid-cycle.
  exp_t m_e;
  int   m_a;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m_e = sb.pop_front();
      m_a = actual(m_e.kind, m_e.lane);
      total++;
      if (m_e.cyc != cyc) begin
        bad++;
        $display("FAIL %s stale expectation cyc=%0d now=%0d", m_e.name, m_e.cyc, cyc);
      end else if (m_a != m_e.val) begin
        bad++;
        $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", m_e.name, cyc, m_a, m_e.val);
      end
    end
    if (cyc > 1) begin
      total++;
      if (count > 5'd16) begin
        bad++;
        $display("FAIL count_le_depth cyc=%0d actual=%0d required<=16", cyc, count);
      end
    end
  end

  task automatic drive(bit ps, int d, bit pl, int len, bit fl, bit rs);
    push = ps; push_data = 8'(d); pull = pl; pull_len = 2'(len);
    flush = fl; queue_reset = rs;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic [7:0] model[$];
  int n;
  bit exp_ack;

  initial begin
    drive(0, 0, 0, 0, 0, 1);
    tick();
    idle();
    chk(K_CNT, 0, 0, "rst_count"); chk(K_FULL, 0, 0, "rst_full");
    chk(K_WV, 0, 0, "rst_wv");     chk(K_OVF, 0, 0, "rst_ovf");
    chk(K_REFILL, 0, 1, "rst_refill");
    tick();

    for (int i = 0; i < 4; i++) begin drive(1, 'h10 + i, 0, 0, 0, 0); tick(); end
    idle();
    chk(K_CNT, 0, 4, "fill4_count");
    chk(K_LANE, 0, 'h10, "fill4_l0"); chk(K_LANE, 1, 'h11, "fill4_l1");
    chk(K_LANE, 2, 'h12, "fill4_l2"); chk(K_WV, 0, 7, "fill4_wv");
    chk(K_REFILL, 0, 1, "fill4_refill");
    tick();

    drive(0, 0, 1, 0, 0, 0); chk(K_ACK, 0, 0, "pull_len0_ack"); tick();
    drive(0, 0, 1, 3, 0, 0); chk(K_ACK, 0, 1, "pull3_ack");     tick();
    drive(0, 0, 1, 2, 0, 0);
    chk(K_CNT, 0, 1, "pull3_count"); chk(K_LANE, 0, 'h13, "pull3_l0");
    chk(K_WV, 0, 1, "pull3_wv");     chk(K_ACK, 0, 0, "pull2_short_ack");
    tick();
    idle(); chk(K_CNT, 0, 1, "pull2_short_count"); tick();
    drive(0, 0, 1, 1, 0, 0); chk(K_ACK, 0, 1, "drain1_ack"); tick();

    for (int i = 0; i < 16; i++) begin drive(1, i, 0, 0, 0, 0); tick(); end
    drive(1, 'hAA, 0, 0, 0, 0);
    chk(K_FULL, 0, 1, "full_flag"); chk(K_CNT, 0, 16, "full_count");
    chk(K_REFILL, 0, 0, "full_refill");
    tick();
    drive(1, 'hBB, 1, 1, 0, 0);
    chk(K_OVF, 0, 1, "ovf_set"); chk(K_ACK, 0, 1, "full_pull_ack");
    chk(K_FULL, 0, 1, "full_still");
    tick();
    idle();
    chk(K_CNT, 0, 15, "pull_full_count"); chk(K_FULL, 0, 0, "pull_full_notfull");
    chk(K_LANE, 0, 'h01, "pull_full_l0"); chk(K_LANE, 1, 'h02, "pull_full_l1");
    chk(K_LANE, 2, 'h03, "pull_full_l2"); chk(K_OVF, 0, 1, "ovf_sticky");
    tick();

    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 3, 0, 0); chk(K_ACK, 0, 1, "drain3_ack"); tick();
    end
    idle(); chk(K_CNT, 0, 0, "drained_count"); tick();

    // Pointers sit at 4; 20 pushes carry the tail across 15->0.
    for (int i = 0; i < 20; i++) begin
      exp_ack = (i % 2 == 1) && (model.size() >= 2);
      drive(1, 'h80 + i, (i % 2 == 1), 2, 0, 0);
      chk(K_ACK, 0, int'(exp_ack), "wrap_ack");
      chk(K_CNT, 0, model.size(), "wrap_count");
      n = (model.size() < 3) ? model.size() : 3;
      for (int l = 0; l < n; l++) chk(K_LANE, l, int'(model[l]), "wrap_lane");
      if (exp_ack) begin void'(model.pop_front()); void'(model.pop_front()); end
      model.push_back(8'('h80 + i));
      tick();
    end
    idle();
    chk(K_CNT, 0, model.size(), "wrap_end_count");
    chk(K_LANE, 0, int'(model[0]), "wrap_end_l0");
    chk(K_LANE, 1, int'(model[1]), "wrap_end_l1");
    tick();

    for (int i = 0; i < 5; i++) begin
      drive(1, 'h90 + i, 0, 0, 0, 0); model.push_back(8'('h90 + i)); tick();
    end
    idle(); chk(K_CNT, 0, 7, "pre_flush_count"); tick();
    drive(1, 'h55, 1, 1, 1, 0);
    chk(K_ACK, 0, 0, "flush_ack"); chk(K_REFILL, 0, 0, "flush_refill");
    tick();
    model.delete();
    idle();
    chk(K_CNT, 0, 0, "post_flush_count"); chk(K_WV, 0, 0, "post_flush_wv");
    chk(K_REFILL, 0, 1, "post_flush_refill");
    tick();
    drive(1, 'h66, 0, 0, 0, 0); tick();
    idle();
    chk(K_LANE, 0, 'h66, "after_flush_l0"); chk(K_CNT, 0, 1, "after_flush_count");
    chk(K_WV, 0, 1, "after_flush_wv");
    tick();

    for (int i = 0; i < 8; i++) begin drive(1, 'hA0 + i, 0, 0, 0, 0); tick(); end
    idle(); chk(K_CNT, 0, 9, "pre_rst_count"); chk(K_OVF, 0, 1, "pre_rst_ovf"); tick();
    drive(1, 'h77, 1, 1, 1, 1); tick();
    idle();
    chk(K_CNT, 0, 0, "rst_all_count"); chk(K_OVF, 0, 0, "rst_all_ovf");
    chk(K_FULL, 0, 0, "rst_all_full"); chk(K_WV, 0, 0, "rst_all_wv");
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
